vertex_shader: RTL and testbench

//  Geometry-stage transform: multiplies each incoming 3D vertex (x,y,z, implicit w=1.0) by a

---
 rtl/vertex_shader.sv | 163 ++++++++++++++++
 tb/tb_vertex_shader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_shader.sv
// vertex_shader: (x,y,z,1) times a loadable 4x4 fp32 matrix.
// Three 2-cycle stages: 12 multiplies, 8 pair adds, 4 final adds.
module vertex_shader (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             col_set_in,
    input  logic [3:0][31:0] col_in,
    input  logic             valid_in,
    input  logic [2:0][31:0] vertex_in,
    output logic             valid_out,
    output logic [3:0][31:0] vertex_out
);
    // Unrounded operation result; value = m * 2^(e-127-48)
    typedef struct packed {
        logic               nan;
        logic               inf;
        logic               s;
        logic signed [11:0] e;
        logic [49:0]        m;
    } pre_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic is_zero(input logic [31:0] a);
        return a[30:23] == 8'd0;
    endfunction

    function automatic logic is_inf(input logic [31:0] a);
        return (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    endfunction

    function automatic logic is_nan(input logic [31:0] a);
        return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    endfunction

    function automatic logic [23:0] man24(input logic [31:0] a);
        return is_zero(a) ? 24'd0 : {1'b1, a[22:0]};
    endfunction

    function automatic pre_t mul_pre(input logic [31:0] a, input logic [31:0] b);
        pre_t        r;
        logic [47:0] p;
        p     = {24'd0, man24(a)} * {24'd0, man24(b)};
        r.nan = is_nan(a) | is_nan(b)
              | (is_inf(a) & is_zero(b)) | (is_zero(a) & is_inf(b));
        r.inf = is_inf(a) | is_inf(b);
        r.s   = a[31] ^ b[31];
        r.e   = $signed({4'd0, a[30:23]}) + $signed({4'd0, b[30:23]})
              - 12'sd127;
        r.m   = {p, 2'b00};
        return r;
    endfunction

    function automatic pre_t add_pre(input logic [31:0] a, input logic [31:0] b);
        pre_t        r;
        logic [30:0] fa;
        logic [30:0] fb;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  d;
        logic [49:0] mh;
        logic [49:0] ml;
        logic [49:0] lost;
        logic [49:0] sh;
        fa   = is_zero(a) ? 31'd0 : a[30:0];
        fb   = is_zero(b) ? 31'd0 : b[30:0];
        hi   = (fb > fa) ? b : a;
        lo   = (fb > fa) ? a : b;
        d    = hi[30:23] - lo[30:23];
        mh   = {1'b0, man24(hi), 25'd0};
        ml   = {1'b0, man24(lo), 25'd0};
        // bits shifted out collapse into a sticky lsb
        lost = ml & ((50'd1 << d) - 50'd1);
        sh   = (ml >> d) | {49'd0, |lost};
        r.nan = is_nan(a) | is_nan(b)
              | (is_inf(a) & is_inf(b) & (a[31] ^ b[31]));
        r.inf = is_inf(a) | is_inf(b);
        r.e   = $signed({4'd0, hi[30:23]});
        r.m   = (hi[31] ^ lo[31]) ? mh - sh : mh + sh;
        r.s   = (r.m == 50'd0) ? (a[31] & b[31]) : hi[31];
        return r;
    endfunction

    function automatic logic [31:0] fp_finish(input pre_t p);
        logic [49:0]        m;
        logic signed [11:0] e;
        logic [5:0]         lz;
        logic [23:0]        f;
        logic               inc;
        logic [31:0]        res;
        lz = 6'd0;
        for (int i = 0; i < 50; i++)
            if (p.m[i]) lz = 6'(49 - i);
        m   = p.m << lz;
        e   = p.e + 12'sd1 - $signed({6'd0, lz});
        inc = m[25] & ((|m[24:0]) | m[26]);
        f   = {1'b0, m[48:26]} + {23'd0, inc};
        if (f[23]) e = e + 12'sd1;
        if (p.nan)
            res = QNAN;
        else if (p.inf || e >= 12'sd255)
            res = {p.s, 8'hFF, 23'd0};
        else if (!m[49] || e <= 12'sd0)
            res = {p.s, 31'd0};
        else
            res = {p.s, e[7:0], f[22:0]};
        return res;
    endfunction

    logic [3:0][3:0][31:0] r_col;
    logic [1:0]            r_idx;
    logic [5:0]            r_vld;

    pre_t                  r_a1 [12];
    logic [3:0][31:0]      r_c3_a1;
    logic [31:0]           r_prod [12];
    logic [3:0][31:0]      r_c3_a2;
    pre_t                  r_b1 [8];
    logic [31:0]           r_sum [8];
    pre_t                  r_c1 [4];

    // Datapath; col3 travels alongside so reloads never hit in-flight work
    always_ff @(posedge clk_in) begin
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 4; r++)
                r_a1[c*4+r] <= mul_pre(vertex_in[c], r_col[c][r]);
        r_c3_a1 <= r_col[3];
        for (int i = 0; i < 12; i++)
            r_prod[i] <= fp_finish(r_a1[i]);
        r_c3_a2 <= r_c3_a1;
        for (int r = 0; r < 4; r++) begin
            r_b1[r]   <= add_pre(r_prod[r], r_prod[4+r]);
            r_b1[4+r] <= add_pre(r_prod[8+r], r_c3_a2[r]);
        end
        for (int i = 0; i < 8; i++)
            r_sum[i] <= fp_finish(r_b1[i]);
        for (int r = 0; r < 4; r++)
            r_c1[r] <= add_pre(r_sum[r], r_sum[4+r]);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_col      <= '0;
            r_idx      <= 2'd0;
            r_vld      <= 6'd0;
            vertex_out <= '0;
        end else begin
            if (col_set_in) begin
                r_col[r_idx] <= col_in;
                r_idx        <= r_idx + 2'd1;
            end else begin
                r_idx <= 2'd0;
            end
            r_vld <= {r_vld[4:0], valid_in};
            if (r_vld[4])
                for (int r = 0; r < 4; r++)
                    vertex_out[r] <= fp_finish(r_c1[r]);
        end
    end

    assign valid_out = r_vld[5];

endmodule

// File: tb/tb_vertex_shader.sv
// tb_vertex_shader: directed vectors plus random traffic against
// a real-arithmetic reference model with fp32 rounding.
module tb_vertex_shader;
    logic             clk = 1'b0;
    logic             rst_in;
    logic             col_set_in;
    logic [3:0][31:0] col_in;
    logic             valid_in;
    logic [2:0][31:0] vertex_in;
    logic             valid_out;
    logic [3:0][31:0] vertex_out;

    vertex_shader dut (
        .clk_in     (clk),
        .rst_in     (rst_in),
        .col_set_in (col_set_in),
        .col_in     (col_in),
        .valid_in   (valid_in),
        .vertex_in  (vertex_in),
        .valid_out  (valid_out),
        .vertex_out (vertex_out)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct {
        int           due;
        logic [127:0] v;
    } exp_t;

    typedef struct {
        logic [2:0][31:0] v;
        logic [3:0][31:0] o;
    } vec_t;

    int                    total = 0;
    int                    bad = 0;
    int                    cyc = 0;
    exp_t                  q[$];
    logic [3:0][3:0][31:0] mm;
    logic [1:0]            midx;
    logic [127:0]          last;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // fp32 -> real, denormals read as signed zero
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0)
            d = {f[31], 63'd0};
        else if (f[30:23] == 8'hFF)
            d = {f[31], 11'h7FF, f[22:0], 29'd0};
        else
            d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // real -> fp32 with round-to-nearest-even, flush-to-zero, overflow to inf
    function automatic logic [31:0] r2f(input real x);
        logic [63:0] d;
        logic [24:0] m;
        int          e;
        d = $realtobits(x);
        if (d[62:52] == 11'h7FF)
            return (d[51:0] != 52'd0) ? QNAN : {d[63], 8'hFF, 23'd0};
        if (d[62:52] == 11'd0)
            return {d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        m = {2'b01, d[51:29]};
        if (d[28] && (d[27:0] != 28'd0 || d[29])) m = m + 25'd1;
        if (m[24]) e++;
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [127:0] xform(input logic [3:0][3:0][31:0] m,
                                           input logic [2:0][31:0] v);
        logic [3:0][31:0] o;
        for (int r = 0; r < 4; r++)
            o[r] = fadd(fadd(fmul(v[0], m[0][r]), fmul(v[1], m[1][r])),
                        fadd(fmul(v[2], m[2][r]), m[3][r]));
        return o;
    endfunction

    function automatic logic [31:0] rnd_f();
        int          k;
        logic [31:0] b;
        k = int'($urandom_range(0, 99));
        b = $urandom;
        if (k < 60)      b[30:23] = 8'($urandom_range(110, 140));
        else if (k < 68) b[30:23] = 8'($urandom_range(1, 30));
        else if (k < 76) b[30:23] = 8'($urandom_range(225, 254));
        else if (k < 82) b[30:0] = 31'd0;
        else if (k < 87) b[30:23] = 8'd0;
        else if (k < 90) begin b[30:23] = 8'hFF; b[22:0] = 23'd0; end
        else if (k < 92) begin b[30:23] = 8'hFF; b[22] = 1'b1; end
        else begin b[30:23] = 8'($urandom_range(126, 131)); b[18:0] = 19'd0; end
        return b;
    endfunction

    // One clock: model the edge, then check every output cycle
    task automatic tick();
        exp_t e;
        if (valid_in) begin
            e.due = cyc + 6;
            e.v   = xform(mm, vertex_in);
            q.push_back(e);
        end
        if (col_set_in) begin
            mm[midx] = col_in;
            midx     = midx + 2'd1;
        end else begin
            midx = 2'd0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("valid", {127'd0, valid_out}, 128'd1);
            e    = q.pop_front();
            last = e.v;
        end else begin
            chk("valid", {127'd0, valid_out}, 128'd0);
        end
        chk("data", vertex_out, last);
    endtask

    task automatic await_out(input string nm, input logic [127:0] exp, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid_out && n < 12);
        chk({nm, "_valid"}, {127'd0, valid_out}, 128'd1);
        chk(nm, vertex_out, exp);
    endtask

    task automatic load(input logic [3:0][3:0][31:0] m, input int n);
        for (int c = 0; c < n; c++) begin
            col_set_in = 1'b1;
            col_in     = m[c];
            tick();
        end
        col_set_in = 1'b0;
    endtask

    task automatic send(input logic [2:0][31:0] v);
        valid_in  = 1'b1;
        vertex_in = v;
        tick();
        valid_in  = 1'b0;
    endtask

    initial begin
        logic [3:0][3:0][31:0] m1;
        logic [3:0][3:0][31:0] ident;
        logic [3:0][3:0][31:0] scale2;
        logic [3:0][3:0][31:0] ones;
        logic [3:0][3:0][31:0] mbig;
        logic [127:0]          r71;
        vec_t                  tbl [5];
        int                    n;
        int                    burst;

        m1[0] = {32'h40C00000, 32'h3F800000, 32'h40000000, 32'h41100000};
        m1[1] = {32'h40400000, 32'h00000000, 32'h41100000, 32'h40C00000};
        m1[2] = {32'h3F800000, 32'h40400000, 32'h3F800000, 32'h40A00000};
        m1[3] = {32'h3F800000, 32'h40A00000, 32'h40E00000, 32'h00000000};
        ident = '0;
        scale2 = '0;
        for (int i = 0; i < 4; i++) ident[i][i] = 32'h3F800000;
        for (int i = 0; i < 3; i++) scale2[i][i] = 32'h40000000;
        scale2[3][3] = 32'h3F800000;
        ones = {16{32'h3F800000}};
        mbig = '0;
        mbig[0][0] = 32'h7F7FFFFF;
        mbig[1][1] = 32'hFF800000;
        r71 = {32'h42180000, 32'h41B00000, 32'h41F00000, 32'h428E0000};

        tbl[0] = '{v: {32'h40800000, 32'h3F800000, 32'h40A00000}, o: r71};
        tbl[1] = '{v: {32'h0, 32'h0, 32'h3F800000},
                   o: {32'h40E00000, 32'h40C00000, 32'h41100000, 32'h41100000}};
        tbl[2] = '{v: {32'h0, 32'h3F800000, 32'h0},
                   o: {32'h40800000, 32'h40A00000, 32'h41800000, 32'h40C00000}};
        tbl[3] = '{v: {32'h0, 32'h0, 32'hBF800000},
                   o: {32'hC0A00000, 32'h40800000, 32'h40A00000, 32'hC1100000}};
        tbl[4] = '{v: {32'h0, 32'h0, 32'h0},
                   o: {32'h3F800000, 32'h40A00000, 32'h40E00000, 32'h00000000}};

        rst_in = 1'b0;
        col_set_in = 1'b0;
        col_in = '0;
        valid_in = 1'b0;
        vertex_in = '0;
        mm = '0;
        midx = 2'd0;
        last = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {127'd0, valid_out}, 128'd0);
        chk("reset_data", vertex_out, 128'd0);
        rst_in = 1'b1;

        // Load example matrix and run the vector table
        load(m1, 4);
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].v);
            await_out($sformatf("tbl%0d", i), tbl[i].o, n);
            chk($sformatf("tbl%0d_lat", i), 128'(n), 128'd5);
        end

        // Identity with back-to-back vertices
        load(ident, 4);
        valid_in = 1'b1;
        vertex_in = {32'h40400000, 32'h40000000, 32'h3F800000};
        tick();
        vertex_in = {32'h40C00000, 32'h40A00000, 32'h40800000};
        tick();
        vertex_in = {32'h41100000, 32'h41000000, 32'h40E00000};
        tick();
        valid_in = 1'b0;
        await_out("id0", {32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F800000}, n);
        chk("id0_lat", 128'(n), 128'd3);
        await_out("id1", {32'h3F800000, 32'h40C00000, 32'h40A00000, 32'h40800000}, n);
        chk("id1_lat", 128'(n), 128'd1);
        await_out("id2", {32'h3F800000, 32'h41100000, 32'h41000000, 32'h40E00000}, n);
        chk("id2_lat", 128'(n), 128'd1);

        // Reload while a vertex is in flight, sharing the first edge
        load(m1, 4);
        valid_in = 1'b1;
        vertex_in = tbl[0].v;
        col_set_in = 1'b1;
        col_in = scale2[0];
        tick();
        valid_in = 1'b0;
        for (int c = 1; c < 4; c++) begin
            col_in = scale2[c];
            tick();
        end
        col_set_in = 1'b0;
        send({32'h40400000, 32'h40000000, 32'h3F800000});
        await_out("inflight_old", r71, n);
        await_out("inflight_new",
                  {32'h3F800000, 32'h40C00000, 32'h40800000, 32'h40000000}, n);

        // Aborted load restarts the column index
        load(ones, 2);
        tick();
        load(m1, 4);
        send(tbl[0].v);
        await_out("restart", r71, n);

        // Async reset with two vertices in flight
        load(ident, 4);
        send({32'h40400000, 32'h40000000, 32'h3F800000});
        send({32'h40C00000, 32'h40A00000, 32'h40800000});
        tick();
        #3;
        rst_in = 1'b0;
        #1;
        chk("rst_async_valid", {127'd0, valid_out}, 128'd0);
        chk("rst_async_data", vertex_out, 128'd0);
        q.delete();
        mm = '0;
        midx = 2'd0;
        last = '0;
        @(posedge clk);
        #1;
        cyc++;
        rst_in = 1'b1;
        repeat (10) tick();
        send({32'h40400000, 32'h40000000, 32'h3F800000});
        await_out("rst_zero_mat", 128'd0, n);

        // Overflow and invalid operations
        load(mbig, 4);
        send({32'h0, 32'h0, 32'h40000000});
        await_out("ovf_nan", {32'h0, 32'h0, QNAN, 32'h7F800000}, n);
        send({32'h0, 32'h3F800000, 32'h40000000});
        await_out("ovf_ninf", {32'h0, 32'h0, 32'hFF800000, 32'h7F800000}, n);
        send({32'h0, 32'h0, 32'hC0000000});
        await_out("ovf_neg", {32'h0, 32'h0, QNAN, 32'hFF800000}, n);

        // Random traffic with interleaved and aborted loads
        burst = 0;
        for (int t = 0; t < 3000; t++) begin
            valid_in = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < 3; i++) vertex_in[i] = rnd_f();
            if (burst == 0 && $urandom_range(0, 19) == 0)
                burst = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 4;
            col_set_in = (burst > 0);
            if (burst > 0) burst--;
            for (int i = 0; i < 4; i++) col_in[i] = rnd_f();
            tick();
        end
        valid_in = 1'b0;
        col_set_in = 1'b0;
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
